pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage CPU pipeline. It drives the ClockEnable and flush (async Reset) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, and the PC enable/load. It resolves load-use hazards, taken branches resolved in EX, and multi-cycle EX operations. Every flush it emits is registered and glitch-free, because the stage registers clear asynchronously.

## Interface
- REG_ADDR_BITS, 5, register-index width
- MC_LATENCY, 4, number of Tick-cycles a multi-cycle op occupies EX (≥2)
- Clock  in  1  system clock; all state updates on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Tick  in  1  global advance strobe; state changes only on edges where Tick=1
- id_rs1, id_rs2  in  REG_ADDR_BITS  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  source actually read
- ex_rd  in  REG_ADDR_BITS  destination of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX branch/jump resolved taken
- ex_mc_start  in  1  EX instruction is multi-cycle
- pc_en, pc_load  out  1  PC advance / load branch target
- ifid_en, idex_en, exmem_en, memwb_en  out  1  stage ClockEnable
- ifid_flush, idex_flush  out  1  registered stage clear (active-high)
- commit_en  out  1  gates register-file and data-memory writes
- stall_cycles  out  16  saturating count of non-RUN Tick-cycles

## Operation
- Enables are combinational from the state and inputs. Flush, pc_load and state are registered.
- States: RUN, LU_BUB, BR_FLUSH, MC_WAIT, plus STEP_HOLD with the macro.
- RUN, default: all enables=1, commit_en=1, pc_en=1.
- Hazard priority in RUN: branch > multi-cycle > load-use.
- Taken branch, ex_branch_taken=1 in RUN:
  - Enables stay 1 this cycle.
  - Next state is BR_FLUSH, with ifid_flush=idex_flush=1 and pc_load=1 for one Tick-cycle.
  - Then RUN.
- Load-use, ex_mem_read=1, ex_rd≠0, and (id_use_rs1 with id_rs1==ex_rd, or id_use_rs2 with id_rs2==ex_rd):
  - This cycle: pc_en=ifid_en=0; idex_en, exmem_en, memwb_en stay 1.
  - Next state is LU_BUB, with idex_flush=1 and pc_en=ifid_en=0.
  - Then RUN. Penalty is 2 Tick-cycles.
- Multi-cycle, ex_mc_start=1 with mc_armed=1:
  - All enables and commit_en are 0 from the detection cycle.
  - MC_WAIT runs for MC_LATENCY-1 Tick-cycles, using a down-counter.
  - On exit, clear mc_armed. It is set again on the next cycle where idex_en=1 and Tick=1, so the same instruction does not retrigger.
- In BR_FLUSH and LU_BUB, hazard inputs are ignored because EX holds a bubble.
- stall_cycles increments on every Tick-cycle whose state is not RUN or that has a hazard-stall enable low. It saturates at 0xFFFF.

## Timing
- Reset_n=0: state=RUN, counter=0, mc_armed=1, stall_cycles=0.
  - All enables, commit_en, pc_en, pc_load and flushes are 0. Enables are forced 0 while in reset.
- Reset_n deassertion: outputs follow RUN from the first Clock edge after release.
- Enable response latency is 0 cycles. Flush/pc_load latency is exactly 1 Tick-cycle, and each holds for exactly 1 Tick-cycle.
- Tick=0 cycles: outputs hold, and no state or counter changes.
- Reset mid-MC_WAIT or mid-flush: returns immediately to reset values, and flushes drop asynchronously.

## Configuration
- PIPE_STEP_EN defined:
  - Adds input step_req and state STEP_HOLD.
  - After reset the block sits in STEP_HOLD with all enables 0.
  - A Tick-cycle with step_req=1 advances exactly one RUN-equivalent Tick, then returns to STEP_HOLD.
  - Hazard sequences complete normally, one step per Tick.
- Undefined: no step_req port; STEP_HOLD is not synthesised.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - state enum pipe_state_t
  - MC_LATENCY default
  - REG_ADDR_BITS default
  - constant REG_ZERO = 0
- One sub-module, pipe_hazard_detect: purely combinational load-use comparator, reused by the forwarding unit.

## Test plan
- Load-use: load x5 in EX, ID reads rs1=5, Tick=1 every cycle.
  - Expect pc_en=ifid_en=0 for 2 cycles.
  - Expect idex_flush=1 in the 2nd cycle only.
  - Expect stall_cycles=2.
- Load to rd=0 with rs1=0 → no stall; all enables stay 1.
- Taken branch → next cycle ifid_flush=idex_flush=pc_load=1 for exactly 1 cycle, then all 0.
- ex_mc_start with MC_LATENCY=4 → all enables and commit_en=0 for 4 cycles, no retrigger, stall_cycles=4.
- Branch and load-use together; then Tick=0 for 3 cycles mid-MC_WAIT → branch wins; the counter freezes while Tick=0, and the exit is delayed by 3 cycles.
- Reset_n pulsed low during MC_WAIT → outputs 0 immediately; RUN and enables=1 on the first edge after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// PIPE_STEP_EN adds the single-step hold state.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_BITS_DEF = 5;
  localparam int unsigned MC_LATENCY_DEF    = 4;
  localparam int unsigned REG_ZERO          = 0;
  localparam int unsigned STALL_BITS        = 16;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_LU_BUB    = 3'd1,
    ST_BR_FLUSH  = 3'd2,
`ifdef PIPE_STEP_EN
    ST_MC_WAIT   = 3'd3,
    ST_STEP_HOLD = 3'd4
`else
    ST_MC_WAIT   = 3'd3
`endif
  } pipe_state_t;

  // State the sequencer rests in between instructions.
`ifdef PIPE_STEP_EN
  localparam pipe_state_t ST_HOME = ST_STEP_HOLD;
`else
  localparam pipe_state_t ST_HOME = ST_RUN;
`endif

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use comparator; shared with the forwarding unit.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS = REG_ADDR_BITS_DEF
) (
  input  logic [ADDR_BITS-1:0] rs1,
  input  logic [ADDR_BITS-1:0] rs2,
  input  logic                 use_rs1,
  input  logic                 use_rs2,
  input  logic [ADDR_BITS-1:0] rd,
  input  logic                 mem_read,
  output logic                 load_use_c
);

  always_comb begin
    load_use_c = mem_read && (rd != ADDR_BITS'(REG_ZERO)) &&
                 ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Define PIPE_STEP_EN to add step_req and the STEP_HOLD single-step state.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_BITS = REG_ADDR_BITS_DEF,
  parameter int unsigned MC_LATENCY    = MC_LATENCY_DEF
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     Tick,
`ifdef PIPE_STEP_EN
  input  logic                     step_req,
`endif
  input  logic [REG_ADDR_BITS-1:0] id_rs1,
  input  logic [REG_ADDR_BITS-1:0] id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [REG_ADDR_BITS-1:0] ex_rd,
  input  logic                     ex_mem_read,
  input  logic                     ex_branch_taken,
  input  logic                     ex_mc_start,
  output logic                     pc_en,
  output logic                     pc_load,
  output logic                     ifid_en,
  output logic                     idex_en,
  output logic                     exmem_en,
  output logic                     memwb_en,
  output logic                     ifid_flush,
  output logic                     idex_flush,
  output logic                     commit_en,
  output logic [STALL_BITS-1:0]    stall_cycles
);

  localparam int unsigned CNT_W = (MC_LATENCY > 3) ? $clog2(MC_LATENCY - 1) : 1;

  pipe_state_t      state, state_nxt;
  logic [CNT_W-1:0] mc_cnt, mc_cnt_nxt;
  logic             mc_armed, mc_armed_nxt;
  logic             active;
  logic             load_use;
  logic             step_go, run_like;
  logic             br_hit, mc_hit, lu_hit;
  logic             stall_tick;
  logic             ifid_flush_nxt, idex_flush_nxt, pc_load_nxt;

  pipe_hazard_detect #(
    .ADDR_BITS (REG_ADDR_BITS)
  ) u_detect (
    .rs1        (id_rs1),
    .rs2        (id_rs2),
    .use_rs1    (id_use_rs1),
    .use_rs2    (id_use_rs2),
    .rd         (ex_rd),
    .mem_read   (ex_mem_read),
    .load_use_c (load_use)
  );

  // Hazard priority: branch > multi-cycle > load-use.
  always_comb begin
`ifdef PIPE_STEP_EN
    step_go = (state == ST_STEP_HOLD) && step_req;
`else
    step_go = 1'b0;
`endif
    run_like = active && ((state == ST_RUN) || step_go);
    br_hit   = run_like && ex_branch_taken;
    mc_hit   = run_like && !br_hit && ex_mc_start && mc_armed;
    lu_hit   = run_like && !br_hit && !mc_hit && load_use;
  end

  // Enables are combinational; flushes, pc_load and counters take effect next Tick.
  always_comb begin
    pc_en          = 1'b0;
    ifid_en        = 1'b0;
    idex_en        = 1'b0;
    exmem_en       = 1'b0;
    memwb_en       = 1'b0;
    commit_en      = 1'b0;
    state_nxt      = state;
    mc_cnt_nxt     = mc_cnt;
    mc_armed_nxt   = mc_armed;
    ifid_flush_nxt = 1'b0;
    idex_flush_nxt = 1'b0;
    pc_load_nxt    = 1'b0;
    stall_tick     = 1'b0;
    if (active) begin
      unique case (state)
`ifdef PIPE_STEP_EN
        ST_RUN, ST_STEP_HOLD: begin
`else
        ST_RUN: begin
`endif
          if (run_like) begin
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            idex_en   = 1'b1;
            exmem_en  = 1'b1;
            memwb_en  = 1'b1;
            commit_en = 1'b1;
            state_nxt = ST_HOME;
            if (br_hit) begin
              state_nxt      = ST_BR_FLUSH;
              ifid_flush_nxt = 1'b1;
              idex_flush_nxt = 1'b1;
              pc_load_nxt    = 1'b1;
            end else if (mc_hit) begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_en    = 1'b0;
              exmem_en   = 1'b0;
              memwb_en   = 1'b0;
              commit_en  = 1'b0;
              state_nxt  = ST_MC_WAIT;
              mc_cnt_nxt = CNT_W'(MC_LATENCY - 2);
              stall_tick = 1'b1;
            end else if (lu_hit) begin
              pc_en          = 1'b0;
              ifid_en        = 1'b0;
              state_nxt      = ST_LU_BUB;
              idex_flush_nxt = 1'b1;
              stall_tick     = 1'b1;
            end
          end else begin
            stall_tick = 1'b1;
          end
        end
        ST_LU_BUB: begin
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          commit_en  = 1'b1;
          state_nxt  = ST_HOME;
          stall_tick = 1'b1;
        end
        ST_BR_FLUSH: begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          commit_en  = 1'b1;
          state_nxt  = ST_HOME;
          stall_tick = 1'b1;
        end
        ST_MC_WAIT: begin
          stall_tick = 1'b1;
          if (mc_cnt == '0) begin
            state_nxt    = ST_HOME;
            mc_armed_nxt = 1'b0;
          end else begin
            mc_cnt_nxt = mc_cnt - CNT_W'(1);
          end
        end
        default: state_nxt = ST_HOME;
      endcase
      // Re-arm once a new instruction can enter EX.
      if (idex_en) mc_armed_nxt = 1'b1;
    end
  end

  // Outputs follow RUN only after the first edge following reset release.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= ST_HOME;
      mc_cnt       <= '0;
      mc_armed     <= 1'b1;
      stall_cycles <= '0;
      ifid_flush   <= 1'b0;
      idex_flush   <= 1'b0;
      pc_load      <= 1'b0;
      active       <= 1'b0;
    end else begin
      active <= 1'b1;
      if (active && Tick) begin
        state      <= state_nxt;
        mc_cnt     <= mc_cnt_nxt;
        mc_armed   <= mc_armed_nxt;
        ifid_flush <= ifid_flush_nxt;
        idex_flush <= idex_flush_nxt;
        pc_load    <= pc_load_nxt;
        if (stall_tick && (stall_cycles != {STALL_BITS{1'b1}}))
          stall_cycles <= stall_cycles + STALL_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default build, MC_LATENCY=4).
module tb_pipe_hazard_ctrl;

  localparam int unsigned AW = 5;

  // Output vector order: pc_en ifid idex exmem memwb commit | ifid_flush idex_flush pc_load
  localparam logic [8:0] O_ZERO = 9'b000000_000;
  localparam logic [8:0] O_RUN  = 9'b111111_000;
  localparam logic [8:0] O_LU   = 9'b001111_000;
  localparam logic [8:0] O_LUB  = 9'b001111_010;
  localparam logic [8:0] O_BR   = 9'b111111_111;

  logic          Clock;
  logic          Reset_n;
  logic          Tick;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2;
  logic          ex_mem_read, ex_branch_taken, ex_mc_start;
  logic          pc_en, pc_load, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, commit_en;
  logic [15:0]   stall_cycles;
  logic [8:0]    outs;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(
    .REG_ADDR_BITS (AW),
    .MC_LATENCY    (4)
  ) dut (
    .Clock           (Clock),
    .Reset_n         (Reset_n),
    .Tick            (Tick),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .ex_mc_start     (ex_mc_start),
    .pc_en           (pc_en),
    .pc_load         (pc_load),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .commit_en       (commit_en),
    .stall_cycles    (stall_cycles)
  );

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, commit_en,
                 ifid_flush, idex_flush, pc_load};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_mc_start = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0;
    Tick    = 1'b1;
    clear_inputs();

    // Reset state
    @(negedge Clock); #1;
    chk("reset_outs", 16'(outs), 16'(O_ZERO));
    chk("reset_stall", stall_cycles, 16'd0);
    @(negedge Clock);
    Reset_n = 1'b1; #1;
    chk("release_pre_edge", 16'(outs), 16'(O_ZERO));
    @(negedge Clock); #1;
    chk("run_after_release", 16'(outs), 16'(O_RUN));

    // Load-use on rs1
    set_load_use(); #1;
    chk("lu_detect", 16'(outs), 16'(O_LU));
    @(negedge Clock); #1;
    chk("lu_bubble", 16'(outs), 16'(O_LUB));
    @(negedge Clock);
    clear_inputs(); #1;
    chk("lu_done", 16'(outs), 16'(O_RUN));
    chk("lu_stall", stall_cycles, 16'd2);

    // Load to x0 never stalls
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; #1;
    chk("x0_no_stall", 16'(outs), 16'(O_RUN));
    @(negedge Clock); #1;
    chk("x0_still_run", 16'(outs), 16'(O_RUN));
    chk("x0_stall_cnt", stall_cycles, 16'd2);

    // rs2 match only counts when rs2 is read
    ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b0; id_rs1 = 5'd3; id_use_rs1 = 1'b1; #1;
    chk("rs2_unused", 16'(outs), 16'(O_RUN));
    id_use_rs2 = 1'b1; #1;
    chk("rs2_detect", 16'(outs), 16'(O_LU));
    @(negedge Clock); #1;
    chk("rs2_bubble", 16'(outs), 16'(O_LUB));
    @(negedge Clock);
    clear_inputs(); #1;
    chk("rs2_done", 16'(outs), 16'(O_RUN));
    chk("rs2_stall", stall_cycles, 16'd4);

    // Taken branch
    ex_branch_taken = 1'b1; #1;
    chk("br_detect", 16'(outs), 16'(O_RUN));
    @(negedge Clock);
    clear_inputs(); #1;
    chk("br_flush", 16'(outs), 16'(O_BR));
    @(negedge Clock); #1;
    chk("br_done", 16'(outs), 16'(O_RUN));
    chk("br_stall", stall_cycles, 16'd5);

    // Multi-cycle op, held in EX throughout; no retrigger on exit
    ex_mc_start = 1'b1; #1;
    chk("mc_detect", 16'(outs), 16'(O_ZERO));
    for (int i = 1; i <= 3; i++) begin
      @(negedge Clock); #1;
      chk($sformatf("mc_wait%0d", i), 16'(outs), 16'(O_ZERO));
    end
    @(negedge Clock); #1;
    chk("mc_no_retrigger", 16'(outs), 16'(O_RUN));
    chk("mc_stall", stall_cycles, 16'd9);
    @(negedge Clock);
    clear_inputs(); #1;
    chk("mc_next_instr", 16'(outs), 16'(O_RUN));

    // Branch and load-use together: branch wins
    ex_branch_taken = 1'b1; set_load_use(); #1;
    chk("br_lu_detect", 16'(outs), 16'(O_RUN));
    @(negedge Clock);
    clear_inputs(); #1;
    chk("br_lu_flush", 16'(outs), 16'(O_BR));
    @(negedge Clock); #1;
    chk("br_lu_done", 16'(outs), 16'(O_RUN));
    chk("br_lu_stall", stall_cycles, 16'd10);

    // Multi-cycle with a 3-cycle Tick gap in the middle
    ex_mc_start = 1'b1; #1;
    chk("mct_detect", 16'(outs), 16'(O_ZERO));
    @(negedge Clock); #1;
    chk("mct_wait1", 16'(outs), 16'(O_ZERO));
    @(negedge Clock);
    Tick = 1'b0; #1;
    chk("mct_wait2", 16'(outs), 16'(O_ZERO));
    for (int i = 1; i <= 3; i++) begin
      @(negedge Clock); #1;
      chk($sformatf("mct_hold%0d", i), 16'(outs), 16'(O_ZERO));
      chk($sformatf("mct_hold_stall%0d", i), stall_cycles, 16'd12);
    end
    Tick = 1'b1;
    @(negedge Clock); #1;
    chk("mct_last", 16'(outs), 16'(O_ZERO));
    @(negedge Clock); #1;
    chk("mct_exit", 16'(outs), 16'(O_RUN));
    chk("mct_stall", stall_cycles, 16'd14);
    @(negedge Clock);
    clear_inputs(); #1;
    chk("mct_next", 16'(outs), 16'(O_RUN));

    // Reset during MC_WAIT
    @(negedge Clock);
    ex_mc_start = 1'b1; #1;
    chk("rst_mc_detect", 16'(outs), 16'(O_ZERO));
    @(negedge Clock);
    clear_inputs(); #2;
    Reset_n = 1'b0; #1;
    chk("rst_mc_outs", 16'(outs), 16'(O_ZERO));
    chk("rst_mc_stall", stall_cycles, 16'd0);
    @(negedge Clock);
    Reset_n = 1'b1; #1;
    chk("rst_mc_pre_edge", 16'(outs), 16'(O_ZERO));
    @(negedge Clock); #1;
    chk("rst_mc_run", 16'(outs), 16'(O_RUN));

    // Reset during the branch flush drops flushes at once
    ex_branch_taken = 1'b1;
    @(negedge Clock);
    clear_inputs(); #1;
    chk("rst_br_flush", 16'(outs), 16'(O_BR));
    #2;
    Reset_n = 1'b0; #1;
    chk("rst_br_outs", 16'(outs), 16'(O_ZERO));
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock); #1;
    chk("rst_br_run", 16'(outs), 16'(O_RUN));
    chk("rst_br_stall", stall_cycles, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
